// File: rtl/adder_issue_pkg.sv
// Shared definitions for the adder64 issue stage: default widths, latency,
// element-size encodings and the byte-lane element-start decode.
package adder_issue_pkg;

  localparam int unsigned DefLenData = 64;
  localparam int unsigned DefTagW    = 4;
  localparam int unsigned DefLat     = 9;
  localparam int unsigned NumLanes   = 8;

  typedef enum logic [1:0] {
    Esize8  = 2'b00,
    Esize16 = 2'b01,
    Esize32 = 2'b10,
    Esize64 = 2'b11
  } esize_e;

  // Byte lane k begins a new element when k is a multiple of the element size in bytes.
  function automatic logic lane_start(input int unsigned k, input logic [1:0] esize);
    int unsigned mask;
    mask = (32'd1 << esize) - 32'd1;
    return (k & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/adder_issue_if.sv
// Operand/result bus between the issue stage and the adder64 pipeline.
interface adder_issue_if
  import adder_issue_pkg::*;
#(
  parameter int unsigned LEN_DATA = DefLenData
);
  logic                  en;
  logic                  valid;
  logic [LEN_DATA-1:0]   a;
  logic [LEN_DATA-1:0]   b;
  logic [NumLanes-1:0]   cin;
  logic [NumLanes-1:0]   cmsk_n;
  logic [LEN_DATA-1:0]   sum;
  logic                  cout;
  logic                  rdy;

  modport master (
    output en, valid, a, b, cin, cmsk_n,
    input  sum, cout, rdy
  );

  modport slave (
    input  en, valid, a, b, cin, cmsk_n,
    output sum, cout, rdy
  );
endinterface

// File: rtl/adder_lane_ctrl.sv
// Per-byte-lane carry control: break the carry chain at each element start and
// inject the subtract carry-in there.
module adder_lane_ctrl
  import adder_issue_pkg::*;
(
  input  logic [1:0]          esize,
  input  logic                sub,
  output logic [NumLanes-1:0] cin,
  output logic [NumLanes-1:0] cmsk_n
);

  // Decode element starts into carry-in and active-low carry mask.
  always_comb begin
    cin    = '0;
    cmsk_n = '1;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      if (lane_start(k, esize)) begin
        cmsk_n[k] = 1'b0;
        cin[k]    = sub;
      end
    end
  end

endmodule

// File: rtl/adder_issue.sv
// Issue stage for the adder64 pipeline: operand conditioning for add/sub with
// packed element sizes, a sideband tag/esize pipe matched to the adder latency,
// back-pressure via a global pipeline enable, and an in-flight counter.
module adder_issue
  import adder_issue_pkg::*;
#(
  parameter int unsigned LEN_DATA = DefLenData,
  parameter int unsigned TAG_W    = DefTagW,
  parameter int unsigned LAT      = DefLat
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sub,
  input  logic [1:0]          in_esize,
  input  logic [LEN_DATA-1:0] in_a,
  input  logic [LEN_DATA-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  adder_issue_if.master       add,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN_DATA-1:0] out_sum,
  output logic                out_cout,
  output logic [TAG_W-1:0]    out_tag,
  output logic [1:0]          out_esize,
  output logic                busy,
  output logic                seq_err
);

  localparam int unsigned CntW = $clog2(LAT + 1);

  logic                  add_en;
  logic                  accept;
  logic                  out_hs;
  logic [NumLanes-1:0]   lane_cin;
  logic [NumLanes-1:0]   lane_cmsk_n;

  logic [LAT-1:0]            sb_vld_q;
  logic [LAT-1:0][TAG_W-1:0] sb_tag_q;
  logic [LAT-1:0][1:0]       sb_esize_q;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            seq_err_q, seq_err_d;

  // A held result freezes the whole adder and sideband pipe.
  assign add_en   = !(out_valid && !out_ready);
  assign in_ready = add_en;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  adder_lane_ctrl u_lane_ctrl (
    .esize  (in_esize),
    .sub    (in_sub),
    .cin    (lane_cin),
    .cmsk_n (lane_cmsk_n)
  );

  // Drive the adder64 operand bus.
  always_comb begin
    add.en     = add_en;
    add.valid  = in_valid;
    add.a      = in_a;
    add.b      = in_sub ? ~in_b : in_b;
    add.cin    = lane_cin;
    add.cmsk_n = lane_cmsk_n;
  end

  // Result fields come straight from the adder; tag/esize from the sideband tail.
  always_comb begin
    out_valid = add.rdy;
    out_sum   = add.sum;
    out_cout  = add.cout;
    out_tag   = sb_tag_q[LAT-1];
    out_esize = sb_esize_q[LAT-1];
  end

  // Sideband pipe advances in lockstep with the adder enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld_q   <= '0;
      sb_tag_q   <= '0;
      sb_esize_q <= '0;
    end else if (add_en) begin
      for (int unsigned i = LAT - 1; i > 0; i--) begin
        sb_vld_q[i]   <= sb_vld_q[i-1];
        sb_tag_q[i]   <= sb_tag_q[i-1];
        sb_esize_q[i] <= sb_esize_q[i-1];
      end
      sb_vld_q[0]   <= accept;
      sb_tag_q[0]   <= in_tag;
      sb_esize_q[0] <= in_esize;
    end
  end

  // In-flight count; the guards keep a misbehaving adder from wrapping it.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !out_hs && cnt_q != CntW'(LAT)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (out_hs && !accept && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Sticky flag: adder ready disagrees with the sideband valid bit.
  always_comb begin
    seq_err_d = seq_err_q | (add.rdy != sb_vld_q[LAT-1]);
  end

  // Counter and error flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign busy    = (cnt_q != '0);
  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_adder_issue.sv
// Bench for adder_issue: behavioural adder64 model on the slave side of the bus,
// directed vectors with hand-computed results, scoreboard plus monitor.
module tb_adder_issue;

  localparam int LAT = 9;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic [3:0]  tag;
    logic [1:0]  esize;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sub;
  logic [1:0]  in_esize;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
  logic [3:0]  out_tag;
  logic [1:0]  out_esize;
  logic        busy;
  logic        seq_err;

  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;
  bit   mon_en = 1'b1;
  logic force_rdy = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  adder_issue_if #(.LEN_DATA(64)) bus ();

  adder_issue #(.LEN_DATA(64), .TAG_W(4), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sub    (in_sub),
    .in_esize  (in_esize),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .add       (bus.master),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_tag   (out_tag),
    .out_esize (out_esize),
    .busy      (busy),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- adder64 model ----------------
  function automatic logic [64:0] lane_add(input logic [63:0] a, input logic [63:0] b,
                                           input logic [7:0] cin, input logic [7:0] cmsk_n);
    logic        c;
    logic [8:0]  t;
    logic [63:0] s;
    c = 1'b0;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      t = {1'b0, a[8*k+:8]} + {1'b0, b[8*k+:8]} + {8'd0, (cmsk_n[k] ? c : cin[k])};
      s[8*k+:8] = t[7:0];
      c = t[8];
    end
    return {c, s};
  endfunction

  logic [LAT-1:0] m_vld;
  logic [63:0]    m_sum [LAT];
  logic           m_cout [LAT];
  logic [64:0]    m_res;

  assign m_res = lane_add(bus.a, bus.b, bus.cin, bus.cmsk_n);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        m_sum[i]  <= '0;
        m_cout[i] <= 1'b0;
      end
    end else if (bus.en) begin
      m_vld <= {m_vld[LAT-2:0], bus.valid};
      m_sum[0]  <= m_res[63:0];
      m_cout[0] <= m_res[64];
      for (int i = 1; i < LAT; i++) begin
        m_sum[i]  <= m_sum[i-1];
        m_cout[i] <= m_cout[i-1];
      end
    end
  end

  assign bus.sum  = m_sum[LAT-1];
  assign bus.cout = m_cout[LAT-1];
  assign bus.rdy  = m_vld[LAT-1] | force_rdy;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && mon_en && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got tag %0d sum %h, required no result",
                 out_tag, out_sum);
      end else begin
        mon_e = sb.pop_front();
        if ({out_sum, out_cout, out_tag, out_esize} !== mon_e) begin
          errors++;
          $display("FAIL result: got sum %h cout %b tag %0d esize %0d, required sum %h cout %b tag %0d esize %0d",
                   out_sum, out_cout, out_tag, out_esize,
                   mon_e.sum, mon_e.cout, mon_e.tag, mon_e.esize);
        end
      end
      hs_count++;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub,
                      input logic [1:0] es, input logic [3:0] tag,
                      input logic [63:0] exp_sum, input logic exp_cout, input bit push,
                      input bit chk_lanes, input logic [7:0] exp_cin, input logic [7:0] exp_cmsk);
    int n;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_esize = es;
    in_tag   = tag;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    if (chk_lanes) begin
      check("add_cin", 64'(bus.cin), 64'(exp_cin));
      check("add_cmsk_n", 64'(bus.cmsk_n), 64'(exp_cmsk));
    end
    if (push) sb.push_back('{sum: exp_sum, cout: exp_cout, tag: tag, esize: es});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d results pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int seen;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    in_esize  = 2'b00;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_seq_err", 64'(seq_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 64b add with full carry ripple, and latency measurement
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 2'b11, 4'd3,
         64'h0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hFE);
    n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'd9);

    // packed-element vectors back to back
    send(64'h0505_0505_0505_0505, 64'h0101_0101_0101_0101, 1'b1, 2'b00, 4'd5,
         64'h0404_0404_0404_0404, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00);
    send(64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 2'b01, 4'd6,
         64'h0100_0100_0100_0100, 1'b0, 1'b1, 1'b1, 8'h00, 8'hAA);
    send(64'h0000_0001_0000_0000, 64'h1, 1'b1, 2'b10, 4'd7,
         64'h0000_0001_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 8'h11, 8'hEE);
    send(64'h5, 64'h7, 1'b1, 2'b11, 4'd8,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1, 8'h01, 8'hFE);
    drain();
    check("busy_idle", 64'(busy), 64'd0);
    check("seq_err_clean", 64'(seq_err), 64'd0);

    // 12 back-to-back ops with a 5-cycle stall on result 2
    hs_count = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send(64'h1000 + 64'(i), 64'h100, 1'b0, 2'b11, 4'(i),
               64'h1100 + 64'(i), 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        end
        check("busy_in_flight", 64'(busy), 64'd1);
      end
      begin
        int w;
        w = 0;
        do begin
          @(posedge clk);
          #1;
          w++;
        end while (!(out_valid && hs_count == 1) && w < 300);
        if (!(out_valid && hs_count == 1)) begin
          checks++;
          errors++;
          $display("FAIL stall_trigger: got hs_count %0d out_valid %b, required 1 and 1",
                   hs_count, out_valid);
        end else begin
          out_ready = 1'b0;
          repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_tag", 64'(out_tag), 64'd1);
            check("stall_out_sum", out_sum, 64'h1101);
          end
          @(posedge clk);
          #1;
          out_ready = 1'b1;
        end
      end
    join
    drain();
    check("busy_after_last", 64'(busy), 64'd0);

    // reset with 4 ops in flight discards them
    for (int i = 0; i < 4; i++) begin
      send(64'(i), 64'h1, 1'b0, 2'b11, 4'(i), 64'h0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    check("busy_before_reset", 64'(busy), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);
    check("post_reset_out_valid", 64'(out_valid), 64'd0);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_seq_err", 64'(seq_err), 64'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no_result_after_reset", 64'(seen), 64'd0);

    // spurious adder ready sets the sticky error
    mon_en = 1'b0;
    @(posedge clk);
    #1 force_rdy = 1'b1;
    @(posedge clk);
    #1 force_rdy = 1'b0;
    check("seq_err_set", 64'(seq_err), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("seq_err_sticky", 64'(seq_err), 64'd1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("seq_err_reset", 64'(seq_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required completion");
    $fatal(1, "watchdog");
  end

endmodule
